// File: rtl/uart_rx_stream.sv
// UART receiver: 2-flop synchronised rxd, 8N1 framing, words presented on a valid/ready stream port.
// Bit period is fixed at elaboration as CLK_RATE/BAUD_RATE clocks.
module uart_rx_stream #(
   parameter int block_WIDTH = 8,
   parameter int CLK_RATE    = 100000000,
   parameter int BAUD_RATE   = 115200
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rxd,
   output logic [block_WIDTH-1:0] m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   busy,
   output logic                   overrun_error,
   output logic                   frame_error
);

   localparam int P  = CLK_RATE / BAUD_RATE;
   localparam int CW = $clog2(P);
   localparam int IW = $clog2(block_WIDTH + 1);

   localparam logic [CW-1:0] HALF_LOAD = CW'(P / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(P - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(block_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state;
   state_t                 state_next;
   logic                   s1, s2, s3;
   logic [1:0]             live;
   logic                   armed;
   logic [CW-1:0]          cnt;
   logic [IW-1:0]          idx;
   logic [block_WIDTH-1:0] shreg;
   logic                   tick;
   logic                   start_edge;
   logic                   word_done;
   logic                   stop_bad;

   // live marks when s2 holds a real line sample rather than its reset value;
   // armed waits for a genuine high so a line held low across reset cannot start a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         s3    <= 1'b1;
         live  <= '0;
         armed <= 1'b0;
      end else begin
         s1   <= rxd;
         s2   <= s1;
         s3   <= s2;
         live <= {live[0], 1'b1};
         if (live[1] && s2)
            armed <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_edge) state_next = START;
         START:   if (tick) state_next = s2 ? IDLE : DATA;
         DATA:    if (tick && idx == LAST_IDX) state_next = STOP;
         STOP:    if (tick) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      tick       = (cnt == '0);
      start_edge = armed && !s2 && s3;
      busy       = (state != IDLE);
      word_done  = (state == STOP) && tick && s2;
      stop_bad   = (state == STOP) && tick && !s2;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt           <= '0;
         idx           <= '0;
         shreg         <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         overrun_error <= 1'b0;
         frame_error   <= 1'b0;
      end else begin
         overrun_error <= 1'b0;
         frame_error   <= stop_bad;
         case (state)
            IDLE: begin
               if (start_edge)
                  cnt <= HALF_LOAD;
            end
            START: begin
               if (tick) begin
                  cnt <= FULL_LOAD;
                  idx <= '0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DATA: begin
               if (tick) begin
                  shreg <= {s2, shreg[block_WIDTH-1:1]};
                  cnt   <= FULL_LOAD;
                  idx   <= idx + IW'(1);
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            STOP: begin
               if (!tick)
                  cnt <= cnt - CW'(1);
            end
            default: cnt <= '0;
         endcase
         // A completing word wins over the clear; it is an overrun only if the old word was not taken.
         if (word_done) begin
            m_axis_tdata  <= shreg;
            m_axis_tvalid <= 1'b1;
            overrun_error <= m_axis_tvalid && !m_axis_tready;
         end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

endmodule
